// File: rtl/char_buffer_ctl_pkg.sv
// Shared constants, character codes and FSM state type for the character
// buffer write controller.
package char_buffer_ctl_pkg;

    localparam int COLS  = 64;
    localparam int ROWS  = 16;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [7:0] BLANK  = 8'h20;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_BS = 8'h08;

    localparam logic [COL_W-1:0]       LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]       LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W+ROW_W-1:0] LAST_ADDR = (COL_W + ROW_W)'(COLS * ROWS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR_ALL,
        ST_IDLE,
        ST_CLEAR_LINE
    } state_t;

    function automatic logic isPrintable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/char_buffer_ctl.sv
// Write-side controller for the 64x16 character buffer: takes a byte stream,
// handles CR/LF/BS, owns the cursor and performs scroll and full-screen clears.
module char_buffer_ctl
    import char_buffer_ctl_pkg::*;
(
    input  logic               clk,
    input  logic               clr_n,
    input  logic [7:0]         data_in,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic               clear_req,
    output logic [9:0]         buffer_waddr,
    output logic [7:0]         buffer_din,
    output logic               buffer_wen,
    output logic [ROW_W-1:0]   buffer_first_row,
    output logic               buffer_first_row_wen,
    output logic [ROW_W-1:0]   cursor_row,
    output logic [COL_W-1:0]   cursor_col
);

    state_t                    r_state;
    logic [COL_W+ROW_W-1:0]    r_count;
    logic [9:0]                r_waddr;
    logic [7:0]                r_din;
    logic                      r_wen;
    logic [ROW_W-1:0]          r_firstRow;
    logic                      r_firstRowWen;
    logic [ROW_W-1:0]          r_cursorRow;
    logic [COL_W-1:0]          r_cursorCol;

    logic [ROW_W-1:0]          w_physRow;

    // Screen row maps onto the ring of physical rows; 4-bit wrap is intended.
    assign w_physRow = r_firstRow + r_cursorRow;

    assign data_ready           = (r_state == ST_IDLE) && !clear_req;
    assign buffer_waddr         = r_waddr;
    assign buffer_din           = r_din;
    assign buffer_wen           = r_wen;
    assign buffer_first_row     = r_firstRow;
    assign buffer_first_row_wen = r_firstRowWen;
    assign cursor_row           = r_cursorRow;
    assign cursor_col           = r_cursorCol;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state       <= ST_CLEAR_ALL;
            r_count       <= '0;
            r_waddr       <= '0;
            r_din         <= '0;
            r_wen         <= 1'b0;
            r_firstRow    <= '0;
            r_firstRowWen <= 1'b0;
            r_cursorRow   <= '0;
            r_cursorCol   <= '0;
        end else begin
            r_wen         <= 1'b0;
            r_firstRowWen <= 1'b0;
            case (r_state)
                ST_CLEAR_ALL: begin
                    r_wen   <= 1'b1;
                    r_waddr <= r_count;
                    r_din   <= BLANK;
                    if (r_count == '0) begin
                        r_firstRow    <= '0;
                        r_firstRowWen <= 1'b1;
                        r_cursorRow   <= '0;
                        r_cursorCol   <= '0;
                    end
                    if (r_count == LAST_ADDR) begin
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count + 10'd1;
                    end
                end

                // first_row was already advanced, so the new bottom row sits one behind it.
                ST_CLEAR_LINE: begin
                    r_wen   <= 1'b1;
                    r_waddr <= {r_firstRow + LAST_ROW, r_count[COL_W-1:0]};
                    r_din   <= BLANK;
                    if (r_count[COL_W-1:0] == LAST_COL) begin
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count + 10'd1;
                    end
                end

                ST_IDLE: begin
                    if (clear_req) begin
                        r_count <= '0;
                        r_state <= ST_CLEAR_ALL;
                    end else if (data_valid) begin
                        if (isPrintable(data_in)) begin
                            r_wen   <= 1'b1;
                            r_waddr <= {w_physRow, r_cursorCol};
                            r_din   <= data_in;
                            if (r_cursorCol != LAST_COL) begin
                                r_cursorCol <= r_cursorCol + 6'd1;
                            end
                        end else if (data_in == CHR_CR) begin
                            r_cursorCol <= '0;
                        end else if (data_in == CHR_LF) begin
                            if (r_cursorRow != LAST_ROW) begin
                                r_cursorRow <= r_cursorRow + 4'd1;
                            end else begin
                                r_firstRow    <= r_firstRow + 4'd1;
                                r_firstRowWen <= 1'b1;
                                r_count       <= '0;
                                r_state       <= ST_CLEAR_LINE;
                            end
                        end else if (data_in == CHR_BS) begin
                            if (r_cursorCol != '0) begin
                                r_cursorCol <= r_cursorCol - 6'd1;
                            end
                        end
                    end
                end

                default: begin
                    r_count <= '0;
                    r_state <= ST_CLEAR_ALL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_buffer_ctl.sv
// Scoreboard bench for char_buffer_ctl: expected buffer writes and first-row
// loads are queued as bytes are driven and popped as the DUT produces them.
module tb_char_buffer_ctl;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       clear_req = 1'b0;
    logic [9:0] buffer_waddr;
    logic [7:0] buffer_din;
    logic       buffer_wen;
    logic [3:0] buffer_first_row;
    logic       buffer_first_row_wen;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int lastWrCycle = 0;
    int prevWrCycle = 0;

    logic [17:0] wrQ[$];
    logic [3:0]  frQ[$];

    logic [3:0] mRow = '0;
    logic [5:0] mCol = '0;
    logic [3:0] mFirst = '0;

    char_buffer_ctl dut (
        .clk(clk),
        .clr_n(clr_n),
        .data_in(data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .clear_req(clear_req),
        .buffer_waddr(buffer_waddr),
        .buffer_din(buffer_din),
        .buffer_wen(buffer_wen),
        .buffer_first_row(buffer_first_row),
        .buffer_first_row_wen(buffer_first_row_wen),
        .cursor_row(cursor_row),
        .cursor_col(cursor_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Every observed write and first-row load must match the head of its queue.
    always @(negedge clk) begin
        if (clr_n) begin
            if (buffer_wen) begin
                if (wrQ.size() == 0)
                    checkOutput("unexpectedWrite", {14'd0, buffer_waddr, buffer_din}, 32'hFFFF_FFFF);
                else
                    checkOutput("write", {14'd0, buffer_waddr, buffer_din}, {14'd0, wrQ.pop_front()});
                prevWrCycle = lastWrCycle;
                lastWrCycle = cycle;
            end
            if (buffer_first_row_wen) begin
                if (frQ.size() == 0)
                    checkOutput("unexpectedFirstRowWen", {28'd0, buffer_first_row}, 32'hFFFF_FFFF);
                else
                    checkOutput("firstRow", {28'd0, buffer_first_row}, {28'd0, frQ.pop_front()});
            end
        end
    end

    task automatic modelClearAll();
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] a;
            a = i[9:0];
            wrQ.push_back({a, 8'h20});
        end
        frQ.push_back(4'd0);
        mRow = '0;
        mCol = '0;
        mFirst = '0;
    endtask

    task automatic modelByte(input logic [7:0] b);
        logic [3:0] pr;
        pr = mFirst + mRow;
        if (b >= 8'h20 && b <= 8'h7E) begin
            wrQ.push_back({pr, mCol, b});
            if (mCol < 6'd63) mCol = mCol + 6'd1;
        end else if (b == 8'h0D) begin
            mCol = '0;
        end else if (b == 8'h0A) begin
            if (mRow < 4'd15) begin
                mRow = mRow + 4'd1;
            end else begin
                for (int c = 0; c < 64; c++) begin
                    logic [5:0] cc;
                    cc = c[5:0];
                    wrQ.push_back({mFirst, cc, 8'h20});
                end
                mFirst = mFirst + 4'd1;
                frQ.push_back(mFirst);
            end
        end else if (b == 8'h08) begin
            if (mCol > 6'd0) mCol = mCol - 6'd1;
        end
    endtask

    // Called at a negedge; counts negedges with data_ready low, bounded.
    task automatic countReadyLow(output int n);
        n = 0;
        while (!data_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int n;
        countReadyLow(n);
        if (!data_ready) begin
            checkOutput("readyTimeout", 32'd0, 32'd1);
        end else begin
            modelByte(b);
            data_in = b;
            data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
        end
    endtask

    task automatic checkCursor(input string tag);
        checkOutput({tag, "Row"}, {28'd0, cursor_row}, {28'd0, mRow});
        checkOutput({tag, "Col"}, {26'd0, cursor_col}, {26'd0, mCol});
        checkOutput({tag, "First"}, {28'd0, buffer_first_row}, {28'd0, mFirst});
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Ready"}, {31'd0, data_ready}, 32'd0);
        checkOutput({tag, "Wen"}, {31'd0, buffer_wen}, 32'd0);
        checkOutput({tag, "Addr"}, {22'd0, buffer_waddr}, 32'd0);
        checkOutput({tag, "Din"}, {24'd0, buffer_din}, 32'd0);
        checkOutput({tag, "FrWen"}, {31'd0, buffer_first_row_wen}, 32'd0);
        checkOutput({tag, "First"}, {28'd0, buffer_first_row}, 32'd0);
        checkOutput({tag, "Cursor"}, {22'd0, cursor_row, cursor_col}, 32'd0);
    endtask

    initial begin
        int n;
        string s;

        repeat (3) @(negedge clk);
        checkResetState("reset");
        modelClearAll();
        clr_n = 1'b1;
        countReadyLow(n);
        checkOutput("initClearCycles", n, 1024);
        checkCursor("afterInit");

        applyStimulus("A");
        applyStimulus("B");
        @(negedge clk);
        checkOutput("abBackToBack", lastWrCycle - prevWrCycle, 1);
        checkCursor("afterAB");

        applyStimulus(8'h0D);
        for (int i = 0; i < 70; i++) applyStimulus(8'h21 + 8'(i));
        applyStimulus(8'h7E);
        applyStimulus(8'h01);
        applyStimulus(8'h7F);
        checkOutput("colSaturate", {26'd0, cursor_col}, 32'd63);
        applyStimulus(8'h0D);
        applyStimulus(8'h08);
        checkOutput("bsAtZero", {26'd0, cursor_col}, 32'd0);
        applyStimulus("q");
        applyStimulus(8'h08);
        checkCursor("afterBs");

        for (int i = 0; i < 15; i++) applyStimulus(8'h0A);
        checkCursor("row15");
        applyStimulus(8'h0A);
        countReadyLow(n);
        checkOutput("scrollReadyLow", n, 64);
        checkCursor("afterScroll");
        applyStimulus("X");

        for (int i = 0; i < 16; i++) applyStimulus(8'h0A);
        countReadyLow(n);
        checkCursor("after17Scrolls");
        s = "Hi";
        applyStimulus(s[0]);
        applyStimulus(s[1]);

        countReadyLow(n);
        clear_req = 1'b1;
        data_valid = 1'b1;
        data_in = "Z";
        modelClearAll();
        @(negedge clk);
        clear_req = 1'b0;
        data_valid = 1'b0;
        countReadyLow(n);
        checkOutput("clearReqCycles", n, 1024);
        checkCursor("afterClearReq");

        for (int i = 0; i < 16; i++) applyStimulus(8'h0A);
        repeat (10) @(negedge clk);
        #2 clr_n = 1'b0;
        wrQ.delete();
        frQ.delete();
        @(negedge clk);
        checkResetState("midLineReset");
        @(negedge clk);
        modelClearAll();
        clr_n = 1'b1;
        countReadyLow(n);
        checkOutput("restartClearCycles", n, 1024);
        checkCursor("afterRestart");
        applyStimulus("K");
        repeat (3) @(negedge clk);

        checkOutput("wrQueueDrained", wrQ.size(), 0);
        checkOutput("frQueueDrained", frQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
